alu_dispatch: RTL and testbench

- Execute-stage front end that drives the existing ALU's 4-bit AluControl, a and b inputs.
- Accepts decoded RV32I instruction fields and register operands from decode over a valid/ready handshake.
- Translates opcode/funct3/funct7 into ALU control codes and selects operands (rs1/pc, rs2/imm).
- Presents the result through a 2-entry skid-buffered output register, so decode back-pressure never creates a combinational ready path.

---
 rtl/alu_dispatch.sv | 211 +++++++++++++++++++++
 tb/tb_alu_dispatch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// alu_dispatch: execute-stage front end for the existing ALU.
//   Decodes RV32I opcode/funct3/funct7 into the 4-bit AluControl code.
//   Selects ALU operands: a from rs1, pc or zero; b from rs2, imm or shamt.
//   The result is registered behind a 2-entry skid buffer (output register
//   plus one skid register), so in_ready never depends combinationally on
//   out_ready.
// Ports:
//   clk, reset (sync, active-high), flush (drops all buffered entries)
//   in_valid/in_ready      : decode handshake
//   opcode/funct3/funct7   : instruction fields
//   rs1_data/rs2_data/imm/pc : operand sources
//   out_valid/out_ready    : ALU-side handshake
//   alu_control/alu_a/alu_b, slt_en, slt_unsigned, illegal : registered results
// Optional: define ALU_DISPATCH_STATS_EN to add dispatch_count, a 32-bit
//   output-transfer counter that is cleared by reset but not by flush.
module alu_dispatch #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
`ifdef ALU_DISPATCH_STATS_EN
  output logic [31:0]     dispatch_count,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic            slt_en,
  output logic            slt_unsigned,
  output logic            illegal
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]      ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            slt_en;
    logic            slt_u;
    logic            ill;
  } entry_t;

  // Encoding chosen so bit[1] is out_valid and bit[0] is skid_valid; both
  // handshake outputs then come straight from state flops.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  state_t r_state;
  entry_t r_out;
  entry_t r_skid;
  entry_t w_dec;
  logic   w_is_op;
  logic   w_in_fire;
  logic   w_out_fire;
  logic [XLEN-1:0] w_shamt;

  assign in_ready     = ~r_state[0];
  assign out_valid    = r_state[1];
  assign w_in_fire    = in_valid & in_ready;
  assign w_out_fire   = out_valid & out_ready;
  assign w_is_op      = (opcode == OPC_OP);
  assign w_shamt      = {{(XLEN-5){1'b0}}, imm[4:0]};

  always_comb begin
    w_dec        = '0;
    w_dec.ctrl   = ALU_ADD;
    w_dec.a      = rs1_data;
    w_dec.b      = imm;
    unique case (opcode)
      OPC_OP, OPC_OPIMM: begin
        if (w_is_op) w_dec.b = rs2_data;
        unique case (funct3)
          3'b000: begin
            if (w_is_op && funct7 == F7_ALT) w_dec.ctrl = ALU_SUB;
            else if (w_is_op && funct7 != F7_BASE) w_dec.ill = 1'b1;
          end
          3'b001: begin
            w_dec.ctrl = ALU_SLL;
            if (!w_is_op) w_dec.b = w_shamt;
            if (funct7 != F7_BASE) w_dec.ill = 1'b1;
          end
          3'b101: begin
            if (!w_is_op) w_dec.b = w_shamt;
            if (funct7 == F7_BASE)     w_dec.ctrl = ALU_SRL;
            else if (funct7 == F7_ALT) w_dec.ctrl = ALU_SRA;
            else                       w_dec.ill  = 1'b1;
          end
          default: begin
            unique case (funct3)
              3'b010:  begin w_dec.ctrl = ALU_SUB; w_dec.slt_en = 1'b1; end
              3'b011:  begin
                w_dec.ctrl   = ALU_SUB;
                w_dec.slt_en = 1'b1;
                w_dec.slt_u  = 1'b1;
              end
              3'b100:  w_dec.ctrl = ALU_XOR;
              3'b110:  w_dec.ctrl = ALU_OR;
              default: w_dec.ctrl = ALU_AND;
            endcase
            if (w_is_op && funct7 != F7_BASE) w_dec.ill = 1'b1;
          end
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: ;
      OPC_BRANCH: begin
        w_dec.ctrl = ALU_SUB;
        w_dec.b    = rs2_data;
      end
      OPC_LUI:            w_dec.a = '0;
      OPC_AUIPC, OPC_JAL: w_dec.a = pc;
      default:            w_dec.ill = 1'b1;
    endcase
    if (w_dec.ill) begin
      w_dec      = '0;
      w_dec.ctrl = ALU_ADD;
      w_dec.ill  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_EMPTY;
      r_out        <= '0;
      r_out.ctrl   <= ALU_ADD;
      r_skid       <= '0;
      r_skid.ctrl  <= ALU_ADD;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_out   <= w_dec;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_out <= w_dec;
          end else if (w_in_fire) begin
            r_skid  <= w_dec;
            r_state <= ST_FULL;
          end else if (w_out_fire) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            r_out   <= r_skid;
            r_state <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign alu_control  = r_out.ctrl;
  assign alu_a        = r_out.a;
  assign alu_b        = r_out.b;
  assign slt_en       = r_out.slt_en;
  assign slt_unsigned = r_out.slt_u;
  assign illegal      = r_out.ill;

`ifdef ALU_DISPATCH_STATS_EN
  logic [31:0] r_dispatch_count;

  always_ff @(posedge clk) begin
    if (reset)           r_dispatch_count <= '0;
    else if (w_out_fire) r_dispatch_count <= r_dispatch_count + 32'd1;
  end

  assign dispatch_count = r_dispatch_count;
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
module tb_alu_dispatch;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, imm, pc, alu_a, alu_b;
  logic [3:0]  alu_control;
  logic        slt_en, slt_unsigned, illegal;

  always #5 clk = ~clk;

  alu_dispatch #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .slt_en(slt_en), .slt_unsigned(slt_unsigned), .illegal(illegal)
  );

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        slt;
    logic        sltu;
    logic        ill;
  } exp_t;

  localparam exp_t RST_VAL = '{ctrl: 4'b0010, a: 32'd0, b: 32'd0, slt: 1'b0, sltu: 1'b0, ill: 1'b0};

  exp_t q[$];
  exp_t shown;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference decode written straight from the instruction-class rules.
  function automatic exp_t ref_dec(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] r1,
                                   input logic [31:0] r2, input logic [31:0] im,
                                   input logic [31:0] p);
    exp_t e;
    bit   legal = 1'b1;
    bit   is_op = (op == 7'h33);
    e = '{ctrl: 4'b0010, a: r1, b: im, slt: 1'b0, sltu: 1'b0, ill: 1'b0};
    if (op == 7'h33 || op == 7'h13) begin
      if (is_op) e.b = r2;
      else if (f3 == 3'd1 || f3 == 3'd5) e.b = im % 32;
      case (f3)
        3'd0: e.ctrl = (is_op && f7 == 7'h20) ? 4'b0110 : 4'b0010;
        3'd1: e.ctrl = 4'b1111;
        3'd2: begin e.ctrl = 4'b0110; e.slt = 1'b1; end
        3'd3: begin e.ctrl = 4'b0110; e.slt = 1'b1; e.sltu = 1'b1; end
        3'd4: e.ctrl = 4'b0011;
        3'd5: e.ctrl = (f7 == 7'h20) ? 4'b1000 : 4'b0111;
        3'd6: e.ctrl = 4'b0001;
        default: e.ctrl = 4'b0000;
      endcase
      if (f3 == 3'd1)      legal = (f7 == 7'h00);
      else if (f3 == 3'd5) legal = (f7 == 7'h00 || f7 == 7'h20);
      else if (is_op)      legal = (f7 == 7'h00) || (f3 == 3'd0 && f7 == 7'h20);
    end else begin
      case (op)
        7'h03, 7'h23, 7'h67: ;
        7'h63: begin e.ctrl = 4'b0110; e.b = r2; end
        7'h37: e.a = 32'd0;
        7'h17, 7'h6f: e.a = p;
        default: legal = 1'b0;
      endcase
    end
    if (!legal) e = '{ctrl: 4'b0010, a: 32'd0, b: 32'd0, slt: 1'b0, sltu: 1'b0, ill: 1'b1};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input bit v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [31:0] p);
    in_valid = v; opcode = op; funct3 = f3; funct7 = f7;
    rs1_data = r1; rs2_data = r2; imm = im; pc = p;
  endtask

  // One clock: advance the model with the currently driven inputs, then
  // compare every output against it just after the edge.
  task automatic cycle();
    bit   in_fire, out_fire;
    exp_t d;
    in_fire  = in_valid && (q.size() < 2);
    out_fire = (q.size() > 0) && out_ready;
    d = ref_dec(opcode, funct3, funct7, rs1_data, rs2_data, imm, pc);
    @(posedge clk);
    if (reset) begin
      q.delete();
      shown = RST_VAL;
    end else if (flush) begin
      q.delete();
    end else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) q.push_back(d);
    end
    if (q.size() > 0) shown = q[0];
    #1;
    chk("in_ready",     {31'd0, in_ready},     {31'd0, q.size() < 2});
    chk("out_valid",    {31'd0, out_valid},    {31'd0, q.size() > 0});
    chk("alu_control",  {28'd0, alu_control}, {28'd0, shown.ctrl});
    chk("alu_a",        alu_a,                 shown.a);
    chk("alu_b",        alu_b,                 shown.b);
    chk("slt_en",       {31'd0, slt_en},       {31'd0, shown.slt});
    chk("slt_unsigned", {31'd0, slt_unsigned}, {31'd0, shown.sltu});
    chk("illegal",      {31'd0, illegal},      {31'd0, shown.ill});
  endtask

  logic [6:0] ops [10];

  initial begin
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h7f};
    shown = RST_VAL;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 7'h33, 3'd0, 7'h00, 32'd1, 32'd2, 32'd3, 32'd4);
    cycle();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;

    // OP ADD
    drive(1'b1, 7'h33, 3'd0, 7'h00, 32'd6, 32'd13, 32'd0, 32'd0);
    cycle();
    chk("add_ctrl", {28'd0, alu_control}, 32'h2);
    chk("add_a", alu_a, 32'd6);
    chk("add_b", alu_b, 32'd13);

    // OP SUB, then SRAI
    drive(1'b1, 7'h33, 3'd0, 7'h20, 32'd5, 32'd6, 32'd0, 32'd0);
    cycle();
    chk("sub_ctrl", {28'd0, alu_control}, 32'h6);
    drive(1'b1, 7'h13, 3'd5, 7'h20, 32'd5, 32'd6, 32'h401, 32'd0);
    cycle();
    chk("srai_ctrl", {28'd0, alu_control}, 32'h8);
    chk("srai_b", alu_b, 32'd1);
    in_valid = 1'b0;
    cycle();

    // Back-pressure: three offered, two accepted, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 7'h33, 3'd0, 7'h00, 32'd100 + i, 32'd200 + i, 32'd0, 32'd0);
      cycle();
    end
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_a", alu_a, 32'd100);
    out_ready = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();

    // SLTU, LUI, AUIPC
    drive(1'b1, 7'h33, 3'd3, 7'h00, 32'd7, 32'd9, 32'd0, 32'd0);
    cycle();
    drive(1'b1, 7'h37, 3'd0, 7'h00, 32'hdead, 32'd0, 32'h12345000, 32'd0);
    cycle();
    chk("lui_a", alu_a, 32'd0);
    chk("lui_b", alu_b, 32'h12345000);
    drive(1'b1, 7'h17, 3'd0, 7'h00, 32'hbeef, 32'd0, 32'h1000, 32'h100);
    cycle();
    chk("auipc_a", alu_a, 32'h100);

    // Flush in FULL with input offered, then flush in ONE with an input transfer
    out_ready = 1'b0;
    drive(1'b1, 7'h13, 3'd4, 7'h00, 32'h11, 32'd0, 32'h22, 32'd0);
    cycle();
    cycle();
    flush = 1'b1;
    cycle();
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
    flush = 1'b0;
    cycle();
    flush = 1'b1;
    drive(1'b1, 7'h63, 3'd1, 7'h00, 32'h33, 32'h44, 32'd0, 32'd0);
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();

    // Illegal OP funct7, then reset mid-stream
    drive(1'b1, 7'h33, 3'd0, 7'h01, 32'd8, 32'd9, 32'd0, 32'd0);
    cycle();
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_ctrl", {28'd0, alu_control}, 32'h2);
    out_ready = 1'b0;
    drive(1'b1, 7'h33, 3'd7, 7'h00, 32'hf0, 32'h0f, 32'd0, 32'd0);
    cycle();
    reset = 1'b1;
    cycle();
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_a", alu_a, 32'd0);
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [6:0] f7r;
      case ($urandom_range(0, 3))
        0: f7r = 7'h00;
        1: f7r = 7'h20;
        2: f7r = 7'h01;
        default: f7r = 7'($urandom);
      endcase
      drive($urandom_range(0, 3) != 0, ops[$urandom_range(0, 9)], 3'($urandom), f7r,
            $urandom, $urandom, $urandom, $urandom);
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 19) == 0;
      reset     = $urandom_range(0, 99) == 0;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
